// File: rtl/replica_pkg.sv
// replica_pkg: shared types for the annealing node array and its run sequencer.
package replica_pkg;

    localparam int city_num_log = 5;

    // Opt selection broadcast to every node.
    typedef enum logic [1:0] {
        OPT_TWO_OPT = 2'd0,
        OPT_OR_OPT  = 2'd1,
        OPT_SWAP    = 2'd2,
        OPT_NONE    = 2'd3
    } opt_command_t;

    localparam int ITER_W = 24;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OPT,
        ST_DIST,
        ST_DRAIN,
        ST_EXP_INIT,
        ST_EXP_RUN,
        ST_EXP_FIN,
        ST_EXCH,
        ST_SHIFT
    } run_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter: loadable down-counter that parks at zero and flags it.
module phase_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load has priority; an enabled count holds at zero instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/node_run_ctrl.sv
// node_run_ctrl: phase sequencer for the node array plus host readout-shift arbitration.
// Outputs are registered from the next state, so strobes line up with the state they belong to.
// Define NODE_RUN_CTRL_PERF_EN to build the saturating busy-cycle counter on perf_cycles.
//
// state        | meaning
// ST_IDLE      | waiting; shift_req beats start
// ST_OPT       | one-cycle opt strobe
// ST_DIST      | city_num delta-distance steps
// ST_DRAIN     | node pipelines settle
// ST_EXP_INIT  | exp unit init strobe
// ST_EXP_RUN   | exp_cycles-long exp window
// ST_EXP_FIN   | exp unit finish strobe
// ST_EXCH      | count iteration, flip pairing, pick next
// ST_SHIFT     | host readout, replica_num+1 cycles, returns to IDLE or OPT
module node_run_ctrl
    import replica_pkg::*;
#(
    parameter int city_num     = 32,
    parameter int replica_num  = 32,
    parameter int drain_cycles = 2,
    parameter int exp_cycles   = 17
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ITER_W-1:0]           iter_num,
    input  opt_command_t                opt_mode,
    input  logic [16:0]                 recip_in,
    input  logic                        abort,
    input  logic                        shift_req,
    output logic                        shift_ack,
    output logic                        busy,
    output logic                        done,
    output logic                        opt_run,
    output opt_command_t                opt_command,
    output logic                        dist_run,
    output logic [$clog2(city_num)-1:0] dist_step,
    output logic                        ex_parity,
    output logic                        exp_init,
    output logic                        exp_run,
    output logic                        exp_fin,
    output logic [16:0]                 exp_recip,
    output logic                        distance_shift,
    output logic                        exchange_shift_d,
    output logic [31:0]                 perf_cycles
);

    localparam int PH_MAX = max_int(max_int(city_num - 1, replica_num),
                                    max_int(drain_cycles - 1, exp_cycles - 1));
    localparam int PH_W   = $clog2(PH_MAX + 1);

    run_state_t        state, nxt;
    logic              ret_opt, ret_opt_nxt;
    logic              done_nxt;
    logic              accept_start;
    logic [PH_W-1:0]   ph_cnt;
    logic              ph_zero;
    logic [ITER_W-1:0] iter_cnt;
    logic              iter_zero_unused;

    // Cycles spent in a state, minus one; single-cycle states load zero.
    function automatic logic [PH_W-1:0] len_m1(input run_state_t s);
        case (s)
            ST_DIST:    return PH_W'(city_num - 1);
            ST_DRAIN:   return PH_W'(drain_cycles - 1);
            ST_EXP_RUN: return PH_W'(exp_cycles - 1);
            ST_SHIFT:   return PH_W'(replica_num);
            default:    return '0;
        endcase
    endfunction

    assign accept_start = (state == ST_IDLE) && !shift_req && start;
    assign busy         = (state != ST_IDLE);

    phase_counter #(.W(PH_W)) u_phase (
        .clk      (clk),
        .reset    (reset),
        .load     (nxt != state),
        .load_val (len_m1(nxt)),
        .en       (1'b1),
        .count    (ph_cnt),
        .zero     (ph_zero)
    );

    phase_counter #(.W(ITER_W)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept_start),
        .load_val (iter_num),
        .en       (state == ST_EXCH),
        .count    (iter_cnt),
        .zero     (iter_zero_unused)
    );

    // Next-state and arbitration; abort outranks everything outside IDLE.
    always_comb begin
        nxt         = state;
        ret_opt_nxt = ret_opt;
        done_nxt    = 1'b0;
        if (state != ST_IDLE && abort) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (shift_req) begin
                        nxt         = ST_SHIFT;
                        ret_opt_nxt = 1'b0;
                    end else if (start) begin
                        if (iter_num != '0) nxt = ST_OPT;
                        else                done_nxt = 1'b1;
                    end
                end
                ST_OPT:      nxt = ST_DIST;
                ST_DIST:     if (ph_zero) nxt = ST_DRAIN;
                ST_DRAIN:    if (ph_zero) nxt = ST_EXP_INIT;
                ST_EXP_INIT: nxt = ST_EXP_RUN;
                ST_EXP_RUN:  if (ph_zero) nxt = ST_EXP_FIN;
                ST_EXP_FIN:  nxt = ST_EXCH;
                ST_EXCH: begin
                    if (iter_cnt <= ITER_W'(1)) begin
                        nxt      = ST_IDLE;
                        done_nxt = 1'b1;
                    end else if (shift_req) begin
                        nxt         = ST_SHIFT;
                        ret_opt_nxt = 1'b1;
                    end else begin
                        nxt = ST_OPT;
                    end
                end
                ST_SHIFT:    if (ph_zero) nxt = ret_opt ? ST_OPT : ST_IDLE;
                default:     nxt = ST_IDLE;
            endcase
        end
    end

    // State register and registered strobes decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            ret_opt          <= 1'b0;
            opt_run          <= 1'b0;
            dist_run         <= 1'b0;
            dist_step        <= '0;
            exp_init         <= 1'b0;
            exp_run          <= 1'b0;
            exp_fin          <= 1'b0;
            distance_shift   <= 1'b0;
            exchange_shift_d <= 1'b0;
            shift_ack        <= 1'b0;
            done             <= 1'b0;
            ex_parity        <= 1'b0;
            opt_command      <= OPT_TWO_OPT;
            exp_recip        <= '0;
        end else begin
            state            <= nxt;
            ret_opt          <= ret_opt_nxt;
            opt_run          <= (nxt == ST_OPT);
            dist_run         <= (nxt == ST_DIST);
            dist_step        <= (nxt == ST_DIST && state == ST_DIST) ? dist_step + 1'b1 : '0;
            exp_init         <= (nxt == ST_EXP_INIT);
            exp_run          <= (nxt == ST_EXP_RUN);
            exp_fin          <= (nxt == ST_EXP_FIN);
            // The readout window spans replica_num+1 cycles: distance first, ordering one behind.
            distance_shift   <= (nxt == ST_SHIFT) && (state != ST_SHIFT || ph_cnt > PH_W'(1));
            exchange_shift_d <= (nxt == ST_SHIFT) && (state == ST_SHIFT);
            shift_ack        <= (nxt == ST_SHIFT) && (state == ST_SHIFT) && (ph_cnt == PH_W'(1));
            done             <= done_nxt;
            // Each run starts on even pairs so its pairing sequence does not depend on history.
            if (state != ST_IDLE && abort) begin
                ex_parity <= 1'b0;
            end else if (accept_start && iter_num != '0) begin
                ex_parity <= 1'b0;
            end else if (state == ST_EXCH) begin
                ex_parity <= ~ex_parity;
            end
            if (accept_start) begin
                opt_command <= opt_mode;
                exp_recip   <= recip_in;
            end
        end
    end

`ifdef NODE_RUN_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: cleared by an accepted start, saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (accept_start) begin
            perf_q <= '0;
        end else if (busy && perf_q != '1) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_node_run_ctrl.sv
// tb_node_run_ctrl: scoreboard bench; each scenario queues the expected per-cycle outputs
// from a schedule model, then pops and compares them as the sequencer runs.
module tb_node_run_ctrl;
    import replica_pkg::*;

    localparam int CITY  = 32;
    localparam int REP   = 32;
    localparam int DRAIN = 2;
    localparam int EXPC  = 17;
`ifdef NODE_RUN_CTRL_PERF_EN
    localparam logic [31:0] PERF_ONE_ITER = 32'd55;
`else
    localparam logic [31:0] PERF_ONE_ITER = 32'd0;
`endif

    logic               clk;
    logic               reset;
    logic               start;
    logic [ITER_W-1:0]  iter_num;
    opt_command_t       opt_mode;
    logic [16:0]        recip_in;
    logic               abort;
    logic               shift_req;
    logic               shift_ack;
    logic               busy;
    logic               done;
    logic               opt_run;
    opt_command_t       opt_command;
    logic               dist_run;
    logic [4:0]         dist_step;
    logic               ex_parity;
    logic               exp_init;
    logic               exp_run;
    logic               exp_fin;
    logic [16:0]        exp_recip;
    logic               distance_shift;
    logic               exchange_shift_d;
    logic [31:0]        perf_cycles;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       opt_run;
        logic       dist_run;
        logic [4:0] dist_step;
        logic       ex_parity;
        logic       exp_init;
        logic       exp_run;
        logic       exp_fin;
        logic       distance_shift;
        logic       exchange_shift_d;
        logic       shift_ack;
    } obs_t;

    obs_t exp_q[$];
    logic cur_par;
    int   n_checks = 0;
    int   n_fail   = 0;

    node_run_ctrl #(
        .city_num     (CITY),
        .replica_num  (REP),
        .drain_cycles (DRAIN),
        .exp_cycles   (EXPC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .iter_num         (iter_num),
        .opt_mode         (opt_mode),
        .recip_in         (recip_in),
        .abort            (abort),
        .shift_req        (shift_req),
        .shift_ack        (shift_ack),
        .busy             (busy),
        .done             (done),
        .opt_run          (opt_run),
        .opt_command      (opt_command),
        .dist_run         (dist_run),
        .dist_step        (dist_step),
        .ex_parity        (ex_parity),
        .exp_init         (exp_init),
        .exp_run          (exp_run),
        .exp_fin          (exp_fin),
        .exp_recip        (exp_recip),
        .distance_shift   (distance_shift),
        .exchange_shift_d (exchange_shift_d),
        .perf_cycles      (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample_obs();
        obs_t s;
        s.busy             = busy;
        s.done             = done;
        s.opt_run          = opt_run;
        s.dist_run         = dist_run;
        s.dist_step        = dist_step;
        s.ex_parity        = ex_parity;
        s.exp_init         = exp_init;
        s.exp_run          = exp_run;
        s.exp_fin          = exp_fin;
        s.distance_shift   = distance_shift;
        s.exchange_shift_d = exchange_shift_d;
        s.shift_ack        = shift_ack;
        return s;
    endfunction

    task automatic push_idle(input int n);
        obs_t v;
        v = '0;
        v.ex_parity = cur_par;
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic push_shift();
        obs_t v;
        for (int j = 0; j <= REP; j++) begin
            v = '0;
            v.busy             = 1'b1;
            v.ex_parity        = cur_par;
            v.distance_shift   = (j < REP);
            v.exchange_shift_d = (j >= 1);
            v.shift_ack        = (j == REP);
            exp_q.push_back(v);
        end
    endtask

    // Schedule model: expected outputs for cycles 1.. after start, done cycle, then idle.
    task automatic push_run(input int iters, input int shift_after, input int trailing);
        obs_t v;
        cur_par = 1'b0;
        for (int i = 0; i < iters; i++) begin
            v = '0;
            v.busy      = 1'b1;
            v.ex_parity = cur_par;
            v.opt_run = 1'b1; exp_q.push_back(v); v.opt_run = 1'b0;
            v.dist_run = 1'b1;
            for (int k = 0; k < CITY; k++) begin
                v.dist_step = 5'(k);
                exp_q.push_back(v);
            end
            v.dist_run = 1'b0; v.dist_step = '0;
            repeat (DRAIN) exp_q.push_back(v);
            v.exp_init = 1'b1; exp_q.push_back(v); v.exp_init = 1'b0;
            v.exp_run = 1'b1; repeat (EXPC) exp_q.push_back(v); v.exp_run = 1'b0;
            v.exp_fin = 1'b1; exp_q.push_back(v); v.exp_fin = 1'b0;
            exp_q.push_back(v);
            cur_par = ~cur_par;
            if (i == shift_after && i != iters - 1) push_shift();
        end
        v = '0;
        v.ex_parity = cur_par;
        v.done      = 1'b1;
        exp_q.push_back(v);
        push_idle(trailing);
    endtask

    task automatic test_reset;
        obs_t o;
        reset = 1'b0; start = 1'b0; abort = 1'b0; shift_req = 1'b0;
        iter_num = '0; opt_mode = OPT_TWO_OPT; recip_in = '0;
        cur_par = 1'b0;
        repeat (3) @(negedge clk);
        o = sample_obs();
        n_checks++;
        if (o !== obs_t'(0)) begin
            n_fail++; $display("FAIL reset_hold got=%h exp=%h", o, obs_t'(0));
        end
        reset = 1'b1;
        @(negedge clk);
        o = sample_obs();
        n_checks++;
        if (o !== obs_t'(0)) begin
            n_fail++; $display("FAIL reset_idle got=%h exp=%h", o, obs_t'(0));
        end
        n_checks++;
        if (opt_command !== OPT_TWO_OPT || exp_recip !== 17'd0 || perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs got cmd=%0d recip=%h perf=%0d exp 0/0/0",
                     opt_command, exp_recip, perf_cycles);
        end
    endtask

    // shift_req and start together in IDLE: the shift wins and start is dropped.
    task automatic test_idle_shift;
        obs_t o, e;
        exp_q.delete();
        push_shift();
        push_idle(2);
        iter_num = 24'd5; opt_mode = OPT_NONE; recip_in = 17'h1FFFF;
        start = 1'b1; shift_req = 1'b1;
        for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); o = sample_obs();
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL idle_shift c=%0d got=%h exp=%h", c, o, e);
            end
            start = 1'b0; shift_req = 1'b0;
        end
        n_checks++;
        if (opt_command !== OPT_TWO_OPT || exp_recip !== 17'd0) begin
            n_fail++;
            $display("FAIL idle_shift_nosample got cmd=%0d recip=%h exp 0/0", opt_command, exp_recip);
        end
    endtask

    task automatic test_single(input opt_command_t om, input logic [16:0] rc);
        obs_t o, e;
        exp_q.delete();
        push_run(1, -1, 2);
        iter_num = 24'd1; opt_mode = om; recip_in = rc; start = 1'b1;
        for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); o = sample_obs();
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL single c=%0d got=%h exp=%h", c, o, e);
            end
            start = 1'b0;
        end
        n_checks++;
        if (opt_command !== om || exp_recip !== rc) begin
            n_fail++;
            $display("FAIL single_cfg got cmd=%0d recip=%h exp cmd=%0d recip=%h",
                     opt_command, exp_recip, om, rc);
        end
        n_checks++;
        if (perf_cycles !== PERF_ONE_ITER) begin
            n_fail++; $display("FAIL single_perf got=%0d exp=%0d", perf_cycles, PERF_ONE_ITER);
        end
    endtask

    task automatic test_zero_iter;
        obs_t o, e, v;
        exp_q.delete();
        v = '0; v.ex_parity = cur_par; v.done = 1'b1;
        exp_q.push_back(v);
        push_idle(3);
        iter_num = '0; start = 1'b1;
        for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); o = sample_obs();
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL zero_iter c=%0d got=%h exp=%h", c, o, e);
            end
            start = 1'b0;
        end
        n_checks++;
        if (perf_cycles !== 32'd0) begin
            n_fail++; $display("FAIL zero_iter_perf got=%0d exp=0", perf_cycles);
        end
    endtask

    // Three iterations with a stray start (and changed iter_num) mid-run that must be ignored.
    task automatic test_multi;
        obs_t o, e;
        exp_q.delete();
        push_run(3, -1, 2);
        iter_num = 24'd3; opt_mode = OPT_OR_OPT; recip_in = 17'h0_1234; start = 1'b1;
        for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); o = sample_obs();
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL multi c=%0d got=%h exp=%h", c, o, e);
            end
            start    = (c == 20);
            iter_num = (c == 20) ? 24'd7 : 24'd3;
        end
        n_checks++;
        if (opt_command !== OPT_OR_OPT || exp_recip !== 17'h0_1234) begin
            n_fail++; $display("FAIL multi_cfg got cmd=%0d recip=%h exp 1/01234", opt_command, exp_recip);
        end
    endtask

    // shift_req raised during the first iteration and dropped inside the shift window.
    task automatic test_shift_mid;
        obs_t o, e;
        exp_q.delete();
        push_run(2, 0, 2);
        iter_num = 24'd2; start = 1'b1;
        for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); o = sample_obs();
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL shift_mid c=%0d got=%h exp=%h", c, o, e);
            end
            start     = 1'b0;
            shift_req = (c >= 10 && c < 60);
        end
    endtask

    // Abort inside the second iteration's exp window: everything drops, parity returns to 0.
    task automatic test_abort;
        obs_t o, e;
        exp_q.delete();
        push_run(2, -1, 0);
        while (exp_q.size() > 95) void'(exp_q.pop_back());
        cur_par = 1'b0;
        push_idle(3);
        iter_num = 24'd2; start = 1'b1;
        for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); o = sample_obs();
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL abort c=%0d got=%h exp=%h", c, o, e);
            end
            start = 1'b0;
            abort = (c == 95);
        end
    endtask

    task automatic test_async_reset;
        obs_t o, e;
        exp_q.delete();
        push_run(1, -1, 0);
        iter_num = 24'd1; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); o = sample_obs();
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL areset_pre c=%0d got=%h exp=%h", c, o, e);
            end
            start = 1'b0;
        end
        exp_q.delete();
        #2 reset = 1'b0;
        #1 o = sample_obs();
        n_checks++;
        if (o !== obs_t'(0)) begin
            n_fail++; $display("FAIL areset_async got=%h exp=%h", o, obs_t'(0));
        end
        @(negedge clk);
        reset = 1'b1;
        cur_par = 1'b0;
        @(negedge clk);
        o = sample_obs();
        n_checks++;
        if (o !== obs_t'(0) || perf_cycles !== 32'd0) begin
            n_fail++; $display("FAIL areset_after got=%h perf=%0d exp=%h perf=0", o, perf_cycles, obs_t'(0));
        end
    endtask

    initial begin
        test_reset();
        test_idle_shift();
        test_single(OPT_SWAP, 17'h1ABCD);
        test_zero_iter();
        test_multi();
        test_shift_mid();
        test_abort();
        test_single(OPT_NONE, 17'h0_0F0F);
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
